// File: rtl/divmod_pkg.sv
// Shared definitions for the iterative restoring divider: FSM state
// encoding and the quotient value reported for a zero divisor.
package divmod_pkg;

    localparam int DIVMOD_WIDTH = 16;

    // Widest operand width the divide-by-zero constant covers; users
    // truncate it to their own WIDTH, which leaves it all ones.
    localparam int DIVMOD_MAX_W = 64;

    localparam logic [DIVMOD_MAX_W-1:0] DBZ_QUOTIENT = {DIVMOD_MAX_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divmod_if.sv
// Operand and result handshake bundle for the divider.
interface divmod_if #(parameter int WIDTH = 16);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] difference;
    logic             div_by_zero;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, quotient, remainder, difference, div_by_zero, out_valid
    );

    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, quotient, remainder, difference, div_by_zero, out_valid
    );

endinterface

// File: rtl/divmod_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, record the quotient bit.
module divmod_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] diff;

    // Shifted remainder keeps its top bit: with a large divisor the partial
    // remainder can have its MSB set, and dropping it would corrupt the compare.
    always_comb begin
        r_sh  = {r, q[WIDTH-1]};
        diff  = r_sh - {1'b0, b};
        if (diff[WIDTH]) begin
            r_nxt = r_sh[WIDTH-1:0];
            q_nxt = {q[WIDTH-2:0], 1'b0};
        end else begin
            r_nxt = diff[WIDTH-1:0];
            q_nxt = {q[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/divmod_verilog.sv
// Iterative unsigned divider: accepts a/b, runs WIDTH restoring steps and
// holds quotient, remainder, a-b and a divide-by-zero flag until consumed.
module divmod_verilog
    import divmod_pkg::*;
#(
    parameter int WIDTH = DIVMOD_WIDTH
) (
    input  logic     clk,
    input  logic     rst_n,
    divmod_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] diff_r;
    logic             dbz_r;

    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             accept;

    assign accept = in_ready_r && bus.in_valid;

    divmod_step #(.WIDTH(WIDTH)) u_step (
        .r     (r_reg),
        .q     (q_reg),
        .b     (b_reg),
        .r_nxt (r_nxt),
        .q_nxt (q_nxt)
    );

    // Working registers need no reset: they are loaded on every accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            r_reg <= '0;
            q_reg <= bus.a;
            b_reg <= bus.b;
        end else if (state == RUN) begin
            r_reg <= r_nxt;
            q_reg <= q_nxt;
        end
    end

    // Control FSM with registered handshake flags and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            quot_r      <= '0;
            rem_r       <= '0;
            diff_r      <= '0;
            dbz_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready_r <= 1'b0;
                        diff_r     <= bus.a - bus.b;
                        if (bus.b == '0) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                            quot_r      <= WIDTH'(DBZ_QUOTIENT);
                            rem_r       <= bus.a;
                            dbz_r       <= 1'b1;
                        end else begin
                            state <= RUN;
                            cnt   <= CNT_W'(WIDTH - 1);
                            dbz_r <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                        quot_r      <= q_nxt;
                        rem_r       <= r_nxt;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.quotient    = quot_r;
    assign bus.remainder   = rem_r;
    assign bus.difference  = diff_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_divmod_verilog.sv
// Directed and randomised checks of the iterative divider.
module tb_divmod_verilog;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [W-1:0] d;
        logic         z;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    divmod_if #(.WIDTH(W)) bus ();

    divmod_verilog #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait for in_ready, present operands for one edge, then scramble them.
    task automatic do_accept(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", bus.in_ready, 1);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 16'hDEAD;
        bus.b        = 16'h0000;
    endtask

    // Edges after the accept edge until out_valid is seen (0 = right after it).
    task automatic wait_valid(output int lat);
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("hs_out_valid_low", bus.out_valid, 0);
        chk("hs_in_ready_high", bus.in_ready, 1);
    endtask

    task automatic check_result(input string tag, input vec_t v);
        chk({tag, "_quotient"}, bus.quotient, v.q);
        chk({tag, "_remainder"}, bus.remainder, v.r);
        chk({tag, "_difference"}, bus.difference, v.d);
        chk({tag, "_dbz"}, bus.div_by_zero, v.z);
    endtask

    initial begin
        vec_t vecs [10];
        vec_t v;
        int   lat;
        int   got;
        int   seen;
        int   n;
        int   hs_count;
        logic ordy;
        logic vld;
        logic [31:0] ra;
        logic [31:0] rb;
        int   sel;

        n_checks = 0;
        n_err    = 0;

        vecs[0] = '{16'd100,   16'd7,      16'd14,    16'd2,      16'd93,     1'b0};
        vecs[1] = '{16'd3,     16'd10,     16'd0,     16'd3,      16'hFFF9,   1'b0};
        vecs[2] = '{16'hFFFF,  16'd1,      16'hFFFF,  16'd0,      16'hFFFE,   1'b0};
        vecs[3] = '{16'd5,     16'd0,      16'hFFFF,  16'd5,      16'd5,      1'b1};
        vecs[4] = '{16'd9,     16'd3,      16'd3,     16'd0,      16'd6,      1'b0};
        vecs[5] = '{16'hFFFF,  16'hFFFF,   16'd1,     16'd0,      16'd0,      1'b0};
        vecs[6] = '{16'h8000,  16'hFFFF,   16'd0,     16'h8000,   16'h8001,   1'b0};
        vecs[7] = '{16'hFFFE,  16'h8001,   16'd1,     16'h7FFD,   16'h7FFD,   1'b0};
        vecs[8] = '{16'd0,     16'd5,      16'd0,     16'd0,      16'hFFFB,   1'b0};
        vecs[9] = '{16'd1000,  16'd33,     16'd30,    16'd10,     16'h03C7,   1'b0};

        rst_n         = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        chk("rst_difference", bus.difference, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            do_accept(v.a, v.b);
            wait_valid(lat);
            chk($sformatf("vec%0d_latency", i), lat, v.z ? 0 : W);
            chk($sformatf("vec%0d_in_ready", i), bus.in_ready, 0);
            check_result($sformatf("vec%0d", i), v);
            handshake();
        end

        // Backpressure with a stray in_valid while results are held
        do_accept(16'd100, 16'd7);
        wait_valid(lat);
        chk("bp_latency", lat, W);
        bus.a        = 16'd1;
        bus.b        = 16'd1;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_quotient", bus.quotient, 14);
            chk("bp_remainder", bus.remainder, 2);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        handshake();
        @(negedge clk);
        chk("bp_no_ghost_op", bus.out_valid, 0);
        chk("bp_idle_ready", bus.in_ready, 1);

        // Reset in the middle of RUN
        do_accept(16'd1234, 16'd7);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_quotient", bus.quotient, 0);
        chk("midrst_remainder", bus.remainder, 0);
        chk("midrst_difference", bus.difference, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_accept(16'd50, 16'd5);
        wait_valid(lat);
        chk("postrst_latency", lat, W);
        v = '{16'd50, 16'd5, 16'd10, 16'd0, 16'd45, 1'b0};
        check_result("postrst", v);
        handshake();

        // Random sweep with random consumer backpressure
        hs_count = 0;
        for (int i = 0; i < 1000; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel < 4) rb = 32'($urandom_range(1, 255));
            v.a = ra[W-1:0];
            v.b = rb[W-1:0];
            if (v.b == 0) begin
                v.q = 16'hFFFF;
                v.r = v.a;
                v.z = 1'b1;
            end else begin
                v.q = v.a / v.b;
                v.r = v.a % v.b;
                v.z = 1'b0;
            end
            v.d = v.a - v.b;
            do_accept(v.a, v.b);
            got  = 0;
            seen = 0;
            n    = 0;
            @(negedge clk);
            while (got == 0 && n < 300) begin
                if (bus.out_valid && seen == 0) begin
                    check_result("rand", v);
                    seen = 1;
                end
                ordy          = 1'($urandom_range(0, 1));
                vld           = bus.out_valid;
                bus.out_ready = ordy;
                @(posedge clk);
                if (vld && ordy) got = 1;
                #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                n++;
            end
            hs_count += got;
            chk("rand_handshake", got, 1);
            chk("rand_single_result", bus.out_valid, 0);
        end
        chk("rand_hs_total", hs_count, 1000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
